// File: rtl/store_rmw_unit_pkg.sv
// store_pkg: shared types and constants for the store read-modify-write unit.
//   store_type_t : StoreTYPE encoding (1=SD, 2=SW, 3=SH, 4=SB; others illegal)
//   state_t      : control FSM states
//   XLEN         : data/address width (only 64 is supported)
package store_pkg;

   localparam int XLEN = 64;

   typedef enum logic [2:0] {
      ST_SD = 3'd1,
      ST_SW = 3'd2,
      ST_SH = 3'd3,
      ST_SB = 3'd4
   } store_type_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic legal_type(input logic [2:0] t);
      return (t >= 3'd1) && (t <= 3'd4);
   endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// store_rmw_unit_if: request side (from the datapath FSM) and memory side of
// the store unit, bundled together.
//   master : drives start/StoreTYPE/addr/wr_data and memory read data
//   slave  : the store unit; drives memory address/write and status
interface store_rmw_unit_if;
   import store_pkg::*;

   logic            start;
   logic [2:0]      StoreTYPE;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wr_data;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_rd_data;
   logic            mem_wr;
   logic [XLEN-1:0] mem_wr_data;
   logic            busy;
   logic            done;
   logic            err;

   modport master (
      output start, StoreTYPE, addr, wr_data, mem_rd_data,
      input  mem_addr, mem_wr, mem_wr_data, busy, done, err
   );

   modport slave (
      input  start, StoreTYPE, addr, wr_data, mem_rd_data,
      output mem_addr, mem_wr, mem_wr_data, busy, done, err
   );

endinterface

// File: rtl/store_rmw_unit_merge.sv
// store_merge: combinational merge of the old doubleword with new store data.
//   old_dw     in  XLEN  doubleword read from memory
//   new_dw     in  XLEN  store source value (bits above store width ignored)
//   store_type in  3     StoreTYPE encoding
//   wr_dw      out XLEN  doubleword to write back
module store_merge
   import store_pkg::*;
(
   input  logic [XLEN-1:0] old_dw,
   input  logic [XLEN-1:0] new_dw,
   input  logic [2:0]      store_type,
   output logic [XLEN-1:0] wr_dw
);

   always_comb begin
      wr_dw = old_dw;
      case (store_type)
         ST_SD:   wr_dw = new_dw;
         ST_SW:   wr_dw = {old_dw[XLEN-1:32], new_dw[31:0]};
         ST_SH:   wr_dw = {old_dw[XLEN-1:16], new_dw[15:0]};
         ST_SB:   wr_dw = {old_dw[XLEN-1:8],  new_dw[7:0]};
         default: wr_dw = old_dw;
      endcase
   end

endmodule

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: writes SD/SW/SH/SB into 64-bit data memory. Partial stores
// read the doubleword, merge the low bytes and write it back; SD writes
// directly; illegal types complete with err and no write.
//   clk, reset : clock, synchronous active-low reset
//   bus        : store_rmw_unit_if.slave (request, memory port, status)
// Outputs are decoded from registered state so nothing depends on start
// combinationally.
module store_rmw_unit #(
   parameter int MEM_RD_LATENCY = 1,   // 1..4
   parameter int XLEN           = 64   // only 64 supported
) (
   input logic                 clk,
   input logic                 reset,
   store_rmw_unit_if.slave     bus
);
   import store_pkg::*;

   state_t          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [2:0]      type_q, type_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdat_q, wdat_d;
   logic [XLEN-1:0] old_q, old_d;
   logic [XLEN-1:0] wd_hold_q, wd_hold_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] merge_out;

   // For SD the old doubleword is ignored by the merge, so old_q need not be
   // valid on the direct IDLE->WRITE path.
   store_merge u_merge (
      .old_dw     (old_q),
      .new_dw     (wdat_q),
      .store_type (type_q),
      .wr_dw      (merge_out)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      type_d    = type_q;
      addr_d    = addr_q;
      wdat_d    = wdat_q;
      old_d     = old_q;
      wd_hold_d = wd_hold_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               type_d = bus.StoreTYPE;
               addr_d = bus.addr;
               wdat_d = bus.wr_data;
               if (!legal_type(bus.StoreTYPE)) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (bus.StoreTYPE == ST_SD) begin
                  state_d = WRITE;
               end else begin
                  cnt_d   = 2'(MEM_RD_LATENCY - 1);
                  state_d = READ;
               end
            end
         end
         READ: begin
            // Read data is valid on the last of MEM_RD_LATENCY READ cycles.
            if (cnt_q == 2'd0) begin
               old_d   = bus.mem_rd_data;
               state_d = WRITE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         WRITE: begin
            wd_hold_d = merge_out;
            state_d   = DONE;
         end
         DONE: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         type_q    <= '0;
         addr_q    <= '0;
         wdat_q    <= '0;
         old_q     <= '0;
         wd_hold_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         type_q    <= type_d;
         addr_q    <= addr_d;
         wdat_q    <= wdat_d;
         old_q     <= old_d;
         wd_hold_q <= wd_hold_d;
         err_q     <= err_d;
      end
   end

   // Write data shows the live merge in WRITE and holds the last written
   // value everywhere else.
   assign bus.mem_wr      = (state_q == WRITE);
   assign bus.mem_wr_data = (state_q == WRITE) ? merge_out : wd_hold_q;
   assign bus.mem_addr    = addr_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = (state_q == DONE);
   assign bus.err         = err_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench: two DUTs (MEM_RD_LATENCY 1 and 3) against a simple
// memory model; expected write data and timing come from mask arithmetic.
module tb_store_rmw_unit;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]        rst_n;
   logic [1:0]        start_s;
   logic [1:0][2:0]   type_s;
   logic [1:0][63:0]  addr_s;
   logic [1:0][63:0]  data_s;

   logic [1:0]        busy_m, done_m, err_m, wr_m;
   logic [1:0][63:0]  wrd_m, maddr_m;

   logic [63:0] mem     [2][64];
   logic [63:0] ref_mem [2][64];
   logic [63:0] last_wd [2];

   int n_cmp = 0;
   int n_bad = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? LAT0 : LAT1;
      int rdk = 0;

      store_rmw_unit_if bus ();

      store_rmw_unit #(.MEM_RD_LATENCY(LAT), .XLEN(64)) dut (
         .clk   (clk),
         .reset (rst_n[g]),
         .bus   (bus.slave)
      );

      assign bus.start     = start_s[g];
      assign bus.StoreTYPE = type_s[g];
      assign bus.addr      = addr_s[g];
      assign bus.wr_data   = data_s[g];
      assign busy_m[g]     = bus.busy;
      assign done_m[g]     = bus.done;
      assign err_m[g]      = bus.err;
      assign wr_m[g]       = bus.mem_wr;
      assign wrd_m[g]      = bus.mem_wr_data;
      assign maddr_m[g]    = bus.mem_addr;

      // Count consecutive read cycles; data is only valid from the LAT-th on,
      // before that the memory returns the inverted word.
      always @(posedge clk)
         rdk <= (bus.busy && !bus.mem_wr && !bus.done) ? rdk + 1 : 0;

      assign bus.mem_rd_data = (rdk >= LAT - 1) ? mem[g][bus.mem_addr[8:3]]
                                                : ~mem[g][bus.mem_addr[8:3]];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_op(input int g, input logic [2:0] typ, input logic [63:0] a,
                         input logic [63:0] d, input bit hold);
      int          lat, exp_lat, done_cyc, wr_n, busy_n, rd_n, rd_addr_bad;
      bit          legal, partial;
      logic [63:0] mask, exp_wd, got_wd, got_wa;
      logic        got_err;
      legal   = (typ >= 3'd1) && (typ <= 3'd4);
      partial = legal && (typ != 3'd1);
      lat     = (g == 0) ? LAT0 : LAT1;
      exp_lat = !legal ? 1 : (partial ? lat + 2 : 2);
      case (typ)
         3'd1:    mask = 64'hFFFF_FFFF_FFFF_FFFF;
         3'd2:    mask = 64'h0000_0000_FFFF_FFFF;
         3'd3:    mask = 64'h0000_0000_0000_FFFF;
         default: mask = 64'h0000_0000_0000_00FF;
      endcase
      exp_wd = (ref_mem[g][a[8:3]] & ~mask) | (d & mask);
      done_cyc = 0; wr_n = 0; busy_n = 0; rd_n = 0; rd_addr_bad = 0;
      got_wd = '0; got_wa = '0; got_err = 1'b0;

      @(negedge clk);
      start_s[g] = 1'b1; type_s[g] = typ; addr_s[g] = a; data_s[g] = d;
      @(posedge clk); #1;
      // Inputs are free to change after accept; with hold, start stays high.
      start_s[g] = hold;
      type_s[g]  = 3'($urandom_range(0, 7));
      addr_s[g]  = {55'd0, 6'($urandom_range(0, 63)), 3'd0};
      data_s[g]  = {$urandom, $urandom};

      for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
         @(negedge clk);
         if (busy_m[g]) busy_n++;
         if (wr_m[g]) begin
            wr_n++;
            got_wd = wrd_m[g];
            got_wa = maddr_m[g];
            mem[g][maddr_m[g][8:3]] = wrd_m[g];
         end else if (busy_m[g] && !done_m[g]) begin
            rd_n++;
            if (maddr_m[g] !== a) rd_addr_bad++;
         end
         if (done_m[g]) begin
            done_cyc = c;
            got_err  = err_m[g];
         end
      end

      chk($sformatf("g%0d t%0d latency", g, typ), done_cyc, exp_lat);
      chk($sformatf("g%0d t%0d err", g, typ), got_err, !legal);
      chk($sformatf("g%0d t%0d wr_count", g, typ), wr_n, legal ? 1 : 0);
      chk($sformatf("g%0d t%0d busy_cycles", g, typ), busy_n, exp_lat);
      chk($sformatf("g%0d t%0d read_cycles", g, typ), rd_n, partial ? lat : 0);
      chk($sformatf("g%0d t%0d read_addr", g, typ), rd_addr_bad, 0);
      if (legal) begin
         chk($sformatf("g%0d t%0d wr_data", g, typ), got_wd, exp_wd);
         chk($sformatf("g%0d t%0d wr_addr", g, typ), got_wa, a);
         ref_mem[g][a[8:3]] = exp_wd;
         last_wd[g] = exp_wd;
      end
      chk($sformatf("g%0d t%0d wd_hold", g, typ), wrd_m[g], last_wd[g]);

      if (hold) begin
         // start was high in the done cycle: must not have been taken.
         @(negedge clk);
         chk($sformatf("g%0d idle_busy", g), busy_m[g], 1'b0);
         chk($sformatf("g%0d idle_wr", g), wr_m[g], 1'b0);
         start_s[g] = 1'b0;
      end
   endtask

   task automatic chk_zero(input int g, input string tag);
      chk($sformatf("g%0d %s busy", g, tag), busy_m[g], 1'b0);
      chk($sformatf("g%0d %s done", g, tag), done_m[g], 1'b0);
      chk($sformatf("g%0d %s err", g, tag), err_m[g], 1'b0);
      chk($sformatf("g%0d %s mem_wr", g, tag), wr_m[g], 1'b0);
      chk($sformatf("g%0d %s mem_addr", g, tag), maddr_m[g], 64'd0);
      chk($sformatf("g%0d %s mem_wr_data", g, tag), wrd_m[g], 64'd0);
   endtask

   initial begin
      int          stray;
      int          g, r;
      logic [2:0]  typ;
      rst_n = 2'b00; start_s = '0; type_s = '0; addr_s = '0; data_s = '0;
      for (int k = 0; k < 2; k++) begin
         last_wd[k] = '0;
         for (int i = 0; i < 64; i++) mem[k][i] = {$urandom, $urandom};
      end
      mem[0][8]  = 64'h0123_4567_89AB_CDEF;
      mem[0][16] = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 64; i++) ref_mem[k][i] = mem[k][i];

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero(0, "reset");
      chk_zero(1, "reset");
      rst_n = 2'b11;

      // Directed cases on the latency-1 unit.
      run_op(0, 3'd1, 64'h100, 64'h1122_3344_5566_7788, 1'b0);
      run_op(0, 3'd4, 64'h40,  64'hFFFF_FFFF_FFFF_FFAB, 1'b0);
      run_op(0, 3'd3, 64'h80,  64'h1234, 1'b1);
      run_op(0, 3'd2, 64'h80,  64'h0, 1'b0);
      run_op(0, 3'd6, 64'h88,  64'hDEAD, 1'b0);
      run_op(0, 3'd0, 64'h90,  64'hBEEF, 1'b0);

      // Latency-3 unit: stale read data on early cycles must be ignored.
      run_op(1, 3'd2, 64'h48, 64'hCAFE_F00D_1357_9BDF, 1'b0);

      // Reset during the read phase of an SB.
      @(negedge clk);
      start_s[1] = 1'b1; type_s[1] = 3'd4; addr_s[1] = 64'h28; data_s[1] = 64'h5A;
      @(posedge clk); #1;
      start_s[1] = 1'b0;
      @(negedge clk);
      chk("g1 pre_reset busy", busy_m[1], 1'b1);
      rst_n[1] = 1'b0;
      @(negedge clk);
      chk_zero(1, "mid_reset");
      rst_n[1] = 1'b1;
      last_wd[1] = '0;
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (wr_m[1] || done_m[1] || busy_m[1]) stray++;
      end
      chk("g1 post_reset activity", stray, 0);
      run_op(1, 3'd1, 64'h30, 64'h0F0E_0D0C_0B0A_0908, 1'b0);

      // Random mix across both units.
      for (int n = 0; n < 40; n++) begin
         g   = $urandom_range(0, 1);
         r   = $urandom_range(0, 9);
         typ = (r > 7) ? 3'(r - 7) : 3'(r);
         run_op(g, typ, {55'd0, 6'($urandom_range(0, 63)), 3'd0},
                {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart of the load sign/zero-extension block. It writes SD/SW/SH/SB data into the 64-bit data memory.
- Partial stores (SW/SH/SB) do a read-modify-write: read the addressed doubleword, replace its low 32/16/8 bits, write the doubleword back.
- SD writes directly with no read.
- Sits between the datapath control FSM and the data memory port.

Parameters:
- MEM_RD_LATENCY, 1, cycles from mem_addr valid to mem_rd_data valid; legal range 1..4.
- XLEN, 64, data and address width; only 64 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- start  in  1  request strobe; sampled only in IDLE.
- StoreTYPE  in  3  1=SD, 2=SW, 3=SH, 4=SB; 0 and 5-7 are illegal.
- addr  in  64  doubleword address, latched at accept.
- wr_data  in  64  store source register value, latched at accept.
- mem_addr  out  64  memory address.
- mem_rd_data  in  64  memory read data.
- mem_wr  out  1  memory write enable.
- mem_wr_data  out  64  memory write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done; 1 = illegal StoreTYPE, no write performed.

Behaviour:
- Reset values: state=IDLE; mem_addr=0, mem_wr=0, mem_wr_data=0, busy=0, done=0, err=0. Latched registers cleared to 0.
- Reset mid-operation: at the next edge go to IDLE. No write and no done pulse are issued after that edge, even from READ or WRITE.
- States: IDLE, READ, WRITE, DONE. All outputs are registered or decoded from state; none depend combinationally on start.
- IDLE, start=1:
  - latch addr, wr_data, StoreTYPE.
  - StoreTYPE=1 -> WRITE.
  - StoreTYPE 2..4 -> READ, rd counter loaded with MEM_RD_LATENCY-1.
  - illegal StoreTYPE -> DONE with err=1.
- IDLE, start=0: stay in IDLE.
- READ:
  - mem_addr = latched addr; mem_wr=0.
  - Counter decrements each cycle. When it is 0, register mem_rd_data into old_q and go to WRITE.
  - Exactly MEM_RD_LATENCY cycles are spent in READ.
- WRITE:
  - Exactly one cycle: mem_wr=1, mem_addr = latched addr.
  - mem_wr_data = merge(old_q, wr_data, type), then go to DONE.
- DONE: done=1 for one cycle, err as decided, busy=1, then go to IDLE.
- Merge rule (bit-exact inverse of load extraction):
  - SD: wr_data.
  - SW: {old[63:32], wr_data[31:0]}.
  - SH: {old[63:16], wr_data[15:0]}.
  - SB: {old[63:8], wr_data[7:0]}.
  - Upper bits of wr_data beyond the store width are ignored. No sign handling.
- Latency from the start edge to done high:
  - SD: 2 cycles.
  - Partial stores: MEM_RD_LATENCY+2 cycles.
  - Illegal type: 1 cycle.
- start while busy: ignored, with no queuing. Inputs may change freely after accept.
- start in the same cycle done is high: ignored. A new request is accepted only in IDLE, i.e. the cycle after done at the earliest.
- mem_wr is never high outside WRITE. mem_wr_data holds its last value outside WRITE.

Decomposition:
- Package store_pkg:
  - store_type_t enum (ST_SD=1, ST_SW=2, ST_SH=3, ST_SB=4).
  - state_t enum (IDLE, READ, WRITE, DONE).
  - XLEN constant.
- One sub-module, store_merge: purely combinational merge of old doubleword, new data and type into the write doubleword. It is instantiated once in store_rmw_unit and is separately unit-testable.

Test Plan:
- SD, addr=0x100, wr_data=0x1122334455667788 -> no READ state; mem_wr high exactly one cycle with data 0x1122334455667788 at 0x100; done 2 cycles after start; err=0.
- SB, addr=0x40, wr_data=0xFFFFFFFFFFFFFFAB, memory holds 0x0123456789ABCDEF, MEM_RD_LATENCY=1 -> write data 0x0123456789ABCDAB; done 3 cycles after start.
- SH then SW back-to-back to 0x80, memory 0xFFFFFFFFFFFFFFFF:
  - SH wr_data=0x1234 -> 0xFFFFFFFFFFFF1234.
  - SW wr_data=0x0 -> 0xFFFFFFFF00000000.
  - Second start held during the first operation is ignored until IDLE.
- StoreTYPE=6 -> done and err high 1 cycle after start; mem_wr never asserted; then StoreTYPE=0 gives the same result.
- MEM_RD_LATENCY=3, SW -> busy for 5 cycles, READ lasts 3 cycles, mem_rd_data captured on the 3rd READ cycle; a changed mem_rd_data on cycle 2 is not used.
- reset=0 during READ of an SB -> next cycle IDLE, all outputs 0, no mem_wr and no done; a following SD completes normally.
